// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and the double-buffer controller state type.
package vga_pkg;

   localparam int unsigned FB_WIDTH  = 320;
   localparam int unsigned FB_HEIGHT = 180;
   localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_DRAW,
      ST_WAIT_SWAP
   } buf_state_e;

endpackage

// File: rtl/vga_buffer_ctrl.sv
// Double-buffer controller: display read addressing, draw writes into the back
// bank, bank swap at end of screen and a clear pass of the new back bank.
module vga_buffer_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned       WIDTH        = FB_WIDTH,
   parameter int unsigned       HEIGHT       = FB_HEIGHT,
   parameter int unsigned       DATA_W       = 8,
   parameter int unsigned       ADDR_W       = 16,
   parameter logic [DATA_W-1:0] CLEAR_COLOUR = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_pix_stb,
   input  logic              i_screenend,
   input  logic [9:0]        i_x,
   input  logic [8:0]        i_y,
   input  logic              i_swap_req,
   output logic              o_swap_ack,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic              o_front,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_data
);

   localparam int unsigned       PIXELS    = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   buf_state_e        state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic              front_q;
   logic              swap_ack_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] rd_addr_d;
   logic              swap_evt;
   logic              wr_in_range;

   // The pixel strobe qualifies the screen-end flag so a long flag swaps once.
   assign swap_evt    = i_screenend & i_pix_stb;
   assign wr_in_range = 32'(i_wr_addr) < PIXELS;
   assign rd_addr_d   = ADDR_W'(32'(i_y) * 32'(WIDTH) + 32'(i_x));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         front_q    <= 1'b0;
         swap_ack_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         swap_ack_q <= 1'b0;
         rd_addr_q  <= rd_addr_d;
         unique case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q == LAST_ADDR) state_q   <= ST_DRAW;
               else                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            end
            ST_DRAW: begin
               if (i_swap_req) state_q <= ST_WAIT_SWAP;
            end
            ST_WAIT_SWAP: begin
               if (swap_evt) begin
                  front_q    <= ~front_q;
                  swap_ack_q <= 1'b1;
                  clr_cnt_q  <= '0;
                  state_q    <= ST_CLEAR;
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   // Write port is decoded from the state; reset holds it idle.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      o_mem_we   = 1'b0;
      o_mem_addr = '0;
      o_mem_data = '0;
      if (!i_rst) begin
         unique case (state_q)
            ST_CLEAR: begin
               o_mem_we   = 1'b1;
               o_mem_addr = clr_cnt_q;
               o_mem_data = CLEAR_COLOUR;
            end
            ST_DRAW: begin
               if (i_wr_req && wr_in_range) begin
                  o_mem_we   = 1'b1;
                  o_mem_addr = i_wr_addr;
                  o_mem_data = i_wr_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_wr_ready = (state_q == ST_DRAW);
   assign o_front    = front_q;
   assign o_swap_ack = swap_ack_q;
   assign o_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_vga_buffer_ctrl.sv
// Directed bench for vga_buffer_ctrl on an 8x4 framebuffer, with a scoreboard of memory writes.
module tb_vga_buffer_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 4;
   localparam int          N  = 32;
   localparam logic [7:0]  CC = 8'h3C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_stb = 1'b0;
   logic        screenend = 1'b0;
   logic        swap_req = 1'b0;
   logic        wr_req = 1'b0;
   logic [9:0]  x = '0;
   logic [8:0]  y = '0;
   logic [15:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        swap_ack, wr_ready, front, mem_we;
   logic [15:0] rd_addr, mem_addr;
   logic [7:0]  mem_data;

   logic [9:0]  bx = '0;
   logic [8:0]  by = '0;
   logic        b_swap_ack, b_wr_ready, b_front, b_mem_we;
   logic [15:0] b_rd_addr, b_mem_addr;
   logic [7:0]  b_mem_data;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fails  = 0;
   int  acks     = 0;

   vga_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .ADDR_W(16), .CLEAR_COLOUR(CC)) dut (
      .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_screenend(screenend),
      .i_x(x), .i_y(y), .i_swap_req(swap_req), .o_swap_ack(swap_ack),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
      .o_front(front), .o_rd_addr(rd_addr), .o_mem_we(mem_we),
      .o_mem_addr(mem_addr), .o_mem_data(mem_data)
   );

   vga_buffer_ctrl dut_full (
      .i_clk(clk), .i_rst(rst), .i_pix_stb(1'b0), .i_screenend(1'b0),
      .i_x(bx), .i_y(by), .i_swap_req(1'b0), .o_swap_ack(b_swap_ack),
      .i_wr_req(1'b0), .i_wr_addr(16'h0000), .i_wr_data(8'h00), .o_wr_ready(b_wr_ready),
      .o_front(b_front), .o_rd_addr(b_rd_addr), .o_mem_we(b_mem_we),
      .o_mem_addr(b_mem_addr), .o_mem_data(b_mem_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst && swap_ack) acks++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_clear();
      for (int i = 0; i < N; i++) exp_q.push_back('{addr: 16'(i), data: CC});
   endtask

   task automatic sample_mem();
      wr_t e;
      if (mem_we) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_fails++;
            $error("FAIL sb_unexpected: observed write addr %0d expected none", mem_addr);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_addr", 32'(mem_addr), 32'(e.addr));
            check("sb_data", 32'(mem_data), 32'(e.data));
         end
      end
   endtask

   initial begin
      repeat (3) tick();
      check("rst_we", 32'(mem_we), 0);
      check("rst_ready", 32'(wr_ready), 0);
      check("rst_front", 32'(front), 0);
      check("rst_ack", 32'(swap_ack), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_data", 32'(mem_data), 0);
      check("rst_rd_addr", 32'(rd_addr), 0);

      // Initial clear of bank 1; a swap request mid-clear must be ignored.
      push_clear();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         swap_req = (i == 5);
         #1;
         check("clr1_we", 32'(mem_we), 1);
         check("clr1_ready", 32'(wr_ready), 0);
         check("clr1_front", 32'(front), 0);
         sample_mem();
         tick();
      end
      swap_req = 1'b0;
      #1;
      check("draw_ready", 32'(wr_ready), 1);
      check("draw_idle_we", 32'(mem_we), 0);
      check("sb_empty_clr1", 32'(exp_q.size()), 0);

      // Draw writes: in-range passes straight through, out-of-range is dropped.
      wr_req = 1'b1; wr_addr = 16'd5; wr_data = 8'hAB;
      exp_q.push_back('{addr: 16'd5, data: 8'hAB});
      #1;
      check("wr5_we", 32'(mem_we), 1);
      sample_mem();
      tick();
      wr_addr = 16'd40; wr_data = 8'hCD;
      #1;
      check("wr40_ready", 32'(wr_ready), 1);
      check("wr40_we", 32'(mem_we), 0);
      tick();

      // Screen end in DRAW without a request: no swap, nothing queued earlier.
      wr_req = 1'b0; screenend = 1'b1; pix_stb = 1'b1;
      tick();
      screenend = 1'b0; pix_stb = 1'b0;
      check("noreq_front", 32'(front), 0);
      check("noreq_ack", 32'(swap_ack), 0);

      // Write in the same cycle as the swap request is still accepted.
      wr_req = 1'b1; wr_addr = 16'd7; wr_data = 8'h55; swap_req = 1'b1;
      exp_q.push_back('{addr: 16'd7, data: 8'h55});
      #1;
      check("wr7_ready", 32'(wr_ready), 1);
      sample_mem();
      tick();
      wr_req = 1'b0; swap_req = 1'b0;
      #1;
      check("wait_ready", 32'(wr_ready), 0);
      check("wait_we", 32'(mem_we), 0);
      tick();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;

      // Screen end held 4 cycles, pixel strobe only on the 3rd.
      push_clear();
      for (int k = 1; k <= 4; k++) begin
         screenend = 1'b1;
         pix_stb   = (k == 3);
         #1;
         check("swap_we", 32'(mem_we), 32'(k == 4));
         sample_mem();
         tick();
         check("swap_front", 32'(front), 32'(k >= 3));
         check("swap_ack", 32'(swap_ack), 32'(k == 3));
      end
      screenend = 1'b0; pix_stb = 1'b0;

      // Clear of bank 0 runs to address 17, where reset cuts in.
      for (int i = 1; i < 17; i++) begin
         #1;
         sample_mem();
         tick();
      end
      rst = 1'b1;
      #1;
      check("rst17_addr_seen", 32'(dut.clr_cnt_q), 17);
      check("rst17_we", 32'(mem_we), 0);
      tick();
      rst = 1'b0;
      #1;
      check("rst17_front", 32'(front), 0);
      check("rst17_mem_addr", 32'(mem_addr), 0);
      check("rst17_we_after", 32'(mem_we), 1);
      check("rst17_ack", 32'(swap_ack), 0);
      exp_q.delete();
      push_clear();
      for (int i = 0; i < N; i++) begin
         #1;
         check("clr2_ready", 32'(wr_ready), 0);
         sample_mem();
         tick();
      end
      #1;
      check("clr2_done_ready", 32'(wr_ready), 1);
      check("clr2_front", 32'(front), 0);
      check("sb_empty_end", 32'(exp_q.size()), 0);
      check("ack_count", 32'(acks), 1);

      // Display read address, one cycle of latency.
      x = 10'd3; y = 9'd2; bx = 10'd319; by = 9'd179;
      tick();
      check("rd_small", 32'(rd_addr), 19);
      check("rd_full_last", 32'(b_rd_addr), 57599);
      bx = 10'd0; by = 9'd1;
      tick();
      check("rd_full_row1", 32'(b_rd_addr), 320);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
